// File: rtl/dwconv_relu_quant_pkg.sv
// Shared constants for the depthwise ReLU/requantize stage: frame geometry,
// lane packing order and int8 saturation bounds.
package dwconv_relu_quant_pkg;

    localparam int unsigned NUM_CH    = 32;
    localparam int unsigned NUM_POS   = 9;
    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned ACC_W     = 32;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned POS_W     = 4;
    localparam int unsigned WORD_W    = NUM_LANES * BYTE_W;

    localparam int unsigned QMAX = 127;
    localparam int unsigned QMIN = 0;

    // Lane 0 lands in the most significant byte of the packed word.
    function automatic int unsigned lane_lsb(input int unsigned lane);
        return (NUM_LANES - 1 - lane) * BYTE_W;
    endfunction

endpackage

// File: rtl/dwconv_relu_quant_if.sv
// Beat-in / buffer-write-out bundle between the bias-add stage, this stage
// and the depthwise output buffer.
interface dwconv_relu_quant_if #(
    parameter int unsigned AW = 9
);
    import dwconv_relu_quant_pkg::*;

    logic               en;
    logic               clr;
    logic               valid_in;
    logic [CNT_W-1:0]   cnt_in;
    logic [POS_W-1:0]   pos_in;
    logic [ACC_W-1:0]   input_data0;
    logic [ACC_W-1:0]   input_data1;
    logic [ACC_W-1:0]   input_data2;
    logic [ACC_W-1:0]   input_data3;

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [WORD_W-1:0]  wr_data;
    logic               frame_done;
    logic               err_pos;

    modport master (
        output en, clr, valid_in, cnt_in, pos_in,
               input_data0, input_data1, input_data2, input_data3,
        input  wr_en, wr_addr, wr_data, frame_done, err_pos
    );

    modport slave (
        input  en, clr, valid_in, cnt_in, pos_in,
               input_data0, input_data1, input_data2, input_data3,
        output wr_en, wr_addr, wr_data, frame_done, err_pos
    );

endinterface

// File: rtl/dwconv_relu_quant_lane.sv
// One lane of the requantizer: ReLU + rounding right-shift (stage 1),
// then saturation to 0..127 (stage 2).
module dwconv_quant_lane
    import dwconv_relu_quant_pkg::*;
#(
    parameter int unsigned SHIFT = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              i_en,
    input  logic [ACC_W-1:0]  i_x,
    output logic [BYTE_W-1:0] o_q
);

    logic [ACC_W:0]    w_ext;
    logic [ACC_W:0]    w_shr;
    logic [BYTE_W-1:0] w_sat;
    logic [ACC_W:0]    r_relu;
    logic [BYTE_W-1:0] r_q;

    // One guard bit so the half-LSB rounding add cannot wrap.
    assign w_ext = {1'b0, i_x};

    if (SHIFT == 0) begin : g_noshift
        assign w_shr = w_ext;
    end else begin : g_round
        localparam logic [ACC_W:0] RND = (ACC_W + 1)'(1) << (SHIFT - 1);
        assign w_shr = (w_ext + RND) >> SHIFT;
    end

    assign w_sat = (r_relu > (ACC_W + 1)'(QMAX)) ? BYTE_W'(QMAX) : r_relu[BYTE_W-1:0];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_relu <= '0;
            r_q    <= '0;
        end else if (i_en) begin
            r_relu <= i_x[ACC_W-1] ? (ACC_W + 1)'(QMIN) : w_shr;
            r_q    <= w_sat;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/dwconv_relu_quant.sv
// Depthwise 3x3 post-processing: ReLU, requantize to int8, pack four lanes
// and write them to the output buffer, flagging the end of each frame.
module dwconv_relu_quant
    import dwconv_relu_quant_pkg::*;
#(
    parameter int unsigned SHIFT   = 8,
    parameter int unsigned NUM_CH  = dwconv_relu_quant_pkg::NUM_CH,
    parameter int unsigned NUM_POS = dwconv_relu_quant_pkg::NUM_POS,
    parameter int unsigned AW      = 9
) (
    input  logic                 clk,
    input  logic                 rst_b,
    dwconv_relu_quant_if.slave   bus
);

    localparam int unsigned TOTAL = NUM_CH * NUM_POS;
    localparam int unsigned CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic                w_idx_ok;
    logic [ACC_W-1:0]    w_x [NUM_LANES];
    logic [BYTE_W-1:0]   w_q [NUM_LANES];
    logic [WORD_W-1:0]   w_packed;

    logic                r_v1;
    logic [CNT_W-1:0]    r_cnt;
    logic [POS_W-1:0]    r_pos;
    logic                r_wr_en;
    logic [AW-1:0]       r_wr_addr;
    logic [CW-1:0]       r_wcnt;
    logic                r_frame_done;
    logic                r_err_pos;

    assign w_idx_ok = (32'(bus.cnt_in) < NUM_CH) && (32'(bus.pos_in) < NUM_POS);

    assign w_x[0] = bus.input_data0;
    assign w_x[1] = bus.input_data1;
    assign w_x[2] = bus.input_data2;
    assign w_x[3] = bus.input_data3;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dwconv_quant_lane #(
            .SHIFT (SHIFT)
        ) u_lane (
            .clk   (clk),
            .rst_b (rst_b),
            .i_en  (bus.en),
            .i_x   (w_x[g]),
            .o_q   (w_q[g])
        );
    end

    always_comb begin
        w_packed = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_packed[lane_lsb(i) +: BYTE_W] = w_q[i];
        end
    end

    // Valid/index pipeline; a stall drops the strobe but holds everything else.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_v1      <= 1'b0;
            r_cnt     <= '0;
            r_pos     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_err_pos <= 1'b0;
        end else if (bus.clr) begin
            r_v1      <= 1'b0;
            r_wr_en   <= 1'b0;
            r_err_pos <= 1'b0;
        end else if (bus.en) begin
            r_v1      <= bus.valid_in & w_idx_ok;
            r_cnt     <= bus.cnt_in;
            r_pos     <= bus.pos_in;
            r_wr_en   <= r_v1;
            r_wr_addr <= AW'(32'(r_cnt) * NUM_POS + 32'(r_pos));
            if (bus.valid_in && !w_idx_ok) begin
                r_err_pos <= 1'b1;
            end
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    // Frame write counter; counts strobes independent of en.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_wcnt       <= '0;
            r_frame_done <= 1'b0;
        end else if (bus.clr) begin
            r_wcnt       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_wr_en) begin
                if (r_wcnt == CW'(TOTAL - 1)) begin
                    r_wcnt       <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + CW'(1);
                end
            end
        end
    end

    assign bus.wr_en      = r_wr_en;
    assign bus.wr_addr    = r_wr_addr;
    assign bus.wr_data    = w_packed;
    assign bus.frame_done = r_frame_done;
    assign bus.err_pos    = r_err_pos;

endmodule
